instr_loader: RTL

//  Boot-time program loader: the writer side of instruction memory, whose words instr_decode reads.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/instr_loader_byte_packer.sv | 58 +++++
 rtl/instr_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants shared with instr_decode and the loader state enum
package cpu_pkg;

  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } load_state_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:27] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - packs received bytes MSB first into 32-bit words
// and discards a partial word after TIMEOUT_CYC idle cycles.
module byte_packer #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        capture,
  input  logic        count_idle,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        word_rdy,
  output logic [31:0] word,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [31:0]   shift;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic          take;
  logic          waiting;

  assign take     = capture && rx_valid;
  assign waiting  = count_idle && !rx_valid && (byte_cnt != 2'd0);
  assign word     = {shift[23:0], rx_data};
  // Word completion only counts while loading; a byte taken during WRITE starts the next word.
  assign word_rdy = take && count_idle && (byte_cnt == 2'd3);
  assign timeout  = waiting && (idle_cnt == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '0;
      byte_cnt <= 2'd0;
      idle_cnt <= '0;
    end else if (clear) begin
      shift    <= '0;
      byte_cnt <= 2'd0;
      idle_cnt <= '0;
    end else if (take) begin
      shift    <= word;
      byte_cnt <= byte_cnt + 2'd1;
      idle_cnt <= '0;
    end else if (timeout) begin
      shift    <= '0;
      byte_cnt <= 2'd0;
      idle_cnt <= '0;
    end else if (waiting) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot loader writing received instruction words to consecutive
// instruction-memory addresses while holding the CPU stalled.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter int                TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] word_count
);

  load_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic              word_rdy;
  logic [31:0]       word;
  logic              timeout;
  logic              addr_last;
  logic              end_load;

  assign addr_last = &addr;
  // Ending in WRITE also flushes the byte that may have been captured in that cycle.
  assign end_load  = (state == ST_WRITE) && (is_halt(imem_wdata) || addr_last);

  byte_packer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (((state == ST_IDLE) && start) || end_load),
    .capture   ((state == ST_LOAD) || (state == ST_WRITE)),
    .count_idle(state == ST_LOAD),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .word_rdy  (word_rdy),
    .word      (word),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_stall  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            cpu_stall  <= 1'b1;
            addr       <= START_ADDR;
            word_count <= '0;
            load_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (timeout) load_err <= 1'b1;
          if (word_rdy) begin
            state      <= ST_WRITE;
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= word;
          end
        end
        ST_WRITE: begin
          imem_we    <= 1'b0;
          word_count <= word_count + 1'b1;
          if (addr_last) begin
            // Top of the address space: stop rather than wrap onto the start of memory.
            load_err  <= 1'b1;
            load_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            addr <= addr + 1'b1;
            if (is_halt(imem_wdata)) begin
              load_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          load_done <= 1'b0;
          cpu_stall <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
